// File: rtl/chan_pkg.sv
// rtl/chan_pkg.sv - shared constants and types for the chan2push block
package chan_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int STATS_W   = 32;
  localparam int DEPTH     = 2;

  typedef logic [1:0] count_t;

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/chan2push_if.sv
// rtl/chan2push_if.sv - channel input and FIFO push output bundle
interface chan2push_if import chan_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
);
  logic [WIDTH-1:0] idata;
  logic             ivalid;
  logic             iready;
  logic [WIDTH-1:0] odata;
  logic             owren;
  logic             ofull;
  logic             oafull;

  modport slave  (input  idata, ivalid, ofull, oafull, output iready, odata, owren);
  modport master (output idata, ivalid, ofull, oafull, input  iready, odata, owren);
endinterface

// File: rtl/chan2push_skid.sv
// rtl/chan2push_skid.sv - 2-entry in-order buffer with bypass when empty
module chan2push_skid import chan_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output count_t           count_o,
  output count_t           count_next_o,
  output logic [WIDTH-1:0] head_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             head_q, head_d;
  count_t           count_q, count_d;
  logic             bypass, store, wr_idx;

  always_comb begin
    // Empty buffer with simultaneous push/pop: the word goes straight out.
    bypass  = push_i && pop_i && (count_q == '0);
    store   = push_i && !bypass;
    wr_idx  = head_q ^ count_q[0];
    head_d  = (pop_i && (count_q != '0)) ? !head_q : head_q;
    count_d = count_q + count_t'(push_i) - count_t'(pop_i);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      head_q  <= 1'b0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (store) begin
      mem_q[wr_idx] <= push_data_i;
    end
  end

  assign count_o      = count_q;
  assign count_next_o = count_d;
  assign head_data_o  = mem_q[head_q];

endmodule

// File: rtl/chan2push.sv
// rtl/chan2push.sv - valid/ready channel to FIFO push adapter; CHAN2PUSH_STATS_EN adds wcount/stalls
module chan2push import chan_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clock,
  input  logic               resetn,
  chan2push_if.slave         bus
`ifdef CHAN2PUSH_STATS_EN
  ,
  output logic [STATS_W-1:0] wcount,
  output logic [STATS_W-1:0] stalls
`endif
);

  logic             iready_q, iready_d;
  logic             owren_q, owren_d;
  logic [WIDTH-1:0] odata_q, odata_d;
  logic             accept, room, issue;
  count_t           count, count_next;
  logic [WIDTH-1:0] head_data;

  chan2push_skid #(.WIDTH(WIDTH)) u_skid (
    .clock        (clock),
    .resetn       (resetn),
    .push_i       (accept),
    .push_data_i  (bus.idata),
    .pop_i        (issue),
    .count_o      (count),
    .count_next_o (count_next),
    .head_data_o  (head_data)
  );

  always_comb begin
    accept   = bus.ivalid && iready_q;
    // A write still in flight while almost full may take the last slot.
    room     = !bus.ofull && !(owren_q && bus.oafull);
    issue    = ((count != '0) || accept) && room;
    owren_d  = issue;
    iready_d = (count_next != count_t'(DEPTH));
    odata_d  = odata_q;
    if (issue) begin
      odata_d = (count == '0) ? bus.idata : head_data;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      iready_q <= 1'b0;
      owren_q  <= 1'b0;
    end else begin
      iready_q <= iready_d;
      owren_q  <= owren_d;
    end
  end

  always_ff @(posedge clock) begin
    odata_q <= odata_d;
  end

  assign bus.iready = iready_q;
  assign bus.owren  = owren_q;
  assign bus.odata  = odata_q;

`ifdef CHAN2PUSH_STATS_EN
  logic [STATS_W-1:0] wcount_q, stalls_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wcount_q <= '0;
      stalls_q <= '0;
    end else begin
      if (owren_q) begin
        wcount_q <= wcount_q + 1'b1;
      end
      if ((count != '0) && !room) begin
        stalls_q <= sat_inc(stalls_q);
      end
    end
  end

  assign wcount = wcount_q;
  assign stalls = stalls_q;
`endif

endmodule

// File: tb/tb_chan2push.sv
// tb/tb_chan2push.sv - randomized scoreboard bench for chan2push
module tb_chan2push;
  import chan_pkg::*;

  localparam int W      = 8;
  localparam int FDEPTH = 4;

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  chan2push_if #(.WIDTH(W)) bif();

`ifdef CHAN2PUSH_STATS_EN
  logic [STATS_W-1:0] wcount, stalls;
  chan2push #(.WIDTH(W)) dut (.clock(clock), .resetn(resetn), .bus(bif), .wcount(wcount), .stalls(stalls));
`else
  chan2push #(.WIDTH(W)) dut (.clock(clock), .resetn(resetn), .bus(bif));
`endif

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0, checks = 0;
  int   cyc = 0, writes = 0, n_acc = 0;
  int   flag_mode = 0;   // 0 manual, 1 FIFO model, 2 random flags
  int   fcnt = 0, read_pct = 0;
  bit   lat_chk = 0;
  bit   prev_ofull = 0, prev_oafull = 0, prev_owren = 0, last_owren = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every write and enforces the flag rules.
  always @(negedge clock) begin
    if (!resetn) begin
      prev_ofull  = 0;
      prev_oafull = 0;
      prev_owren  = 0;
      last_owren  = 0;
    end else begin
      if (prev_ofull) check("no_write_after_ofull", bif.owren, 1'b0);
      if (prev_owren && prev_oafull) check("no_write_after_oafull", bif.owren, 1'b0);
      if (bif.owren === 1'b1) begin
        writes++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got odata %0h expected no write", bif.odata);
        end else begin
          mon_e = sb.pop_front();
          if (bif.odata !== mon_e.data) begin
            errors++;
            $display("FAIL odata: got %0h expected %0h", bif.odata, mon_e.data);
          end
          if (lat_chk) check("latency_cycle", cyc, mon_e.cyc + 1);
        end
      end
      prev_ofull  = bif.ofull;
      prev_oafull = bif.oafull;
      prev_owren  = bif.owren;
      last_owren  = bif.owren;
    end
  end

  // Downstream flags: a depth-FDEPTH FIFO model or random values, updated just after each edge.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (flag_mode == 1) begin
        if (last_owren) begin
          checks++;
          if (fcnt >= FDEPTH) begin
            errors++;
            $display("FAIL fifo_overrun: got write at fill %0d expected fill below %0d", fcnt, FDEPTH);
          end else begin
            fcnt++;
          end
        end
        if (fcnt > 0 && $urandom_range(99) < read_pct) fcnt--;
        bif.ofull  = (fcnt >= FDEPTH);
        bif.oafull = (fcnt >= FDEPTH - 1);
      end else if (flag_mode == 2) begin
        bif.ofull  = ($urandom_range(3) == 0);
        bif.oafull = bif.ofull || ($urandom_range(3) == 0);
      end
    end
  end

  task automatic send(input logic [W-1:0] d);
    int t = 0;
    @(negedge clock);
    bif.ivalid = 1'b1;
    bif.idata  = d;
    while (!bif.iready && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (!bif.iready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got iready 0 for %0d cycles expected 1", t);
      bif.ivalid = 1'b0;
      return;
    end
    @(posedge clock);
    sb.push_back('{data: d, cyc: cyc});
    n_acc++;
  endtask

  task automatic idle(input int n);
    @(negedge clock);
    bif.ivalid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn     = 1'b0;
    bif.ivalid = 1'b0;
    #1;
    check("reset_iready", bif.iready, 1'b0);
    check("reset_owren", bif.owren, 1'b0);
    sb.delete();
    fcnt       = 0;
    bif.ofull  = 1'b0;
    bif.oafull = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    check("iready_after_release", bif.iready, 1'b1);
  endtask

  task automatic drain(input int limit);
    int t = 0;
    while (sb.size() != 0 && t < limit) begin
      @(negedge clock);
      t++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int a0;
    void'($urandom(1));
    bif.ivalid = 1'b0;
    bif.idata  = '0;
    bif.ofull  = 1'b0;
    bif.oafull = 1'b0;
    do_reset();

    // Streaming at one word per clock with one cycle latency.
    flag_mode = 0;
    lat_chk   = 1;
    w0        = writes;
    for (int i = 1; i <= 8; i++) send(W'(i));
    idle(3);
    lat_chk = 0;
    check("stream_writes", writes - w0, 8);

    // Depth-4 FIFO never read: four writes, then the buffer fills.
    do_reset();
    flag_mode = 1;
    read_pct  = 0;
    w0        = writes;
    for (int i = 1; i <= 6; i++) send(W'(i));
    idle(10);
    check("full_writes", writes - w0, 4);
    check("full_iready", bif.iready, 1'b0);
    check("full_buffered", sb.size(), 2);

    // Reset with two words buffered: nothing stale afterwards.
    do_reset();
    w0 = writes;
    repeat (6) @(negedge clock);
    check("no_stale_write", writes, w0);

    // Almost-full held: writes space out, then resume when it drops.
    flag_mode  = 0;
    bif.oafull = 1'b1;
    w0         = writes;
    send(8'hA1);
    send(8'hA2);
    idle(4);
    check("afull_writes", writes - w0, 2);
    bif.oafull = 1'b0;
    w0 = writes;
    for (int i = 0; i < 4; i++) send(W'(8'hB0 + i));
    idle(3);
    check("afull_resume", writes - w0, 4);

    // Toggling ivalid against random flags.
    flag_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      send(W'($urandom_range(255)));
      idle(0);
    end
    @(negedge clock);
    flag_mode  = 0;
    bif.ofull  = 1'b0;
    bif.oafull = 1'b0;
    drain(50);

    // FIFO model with random reads and random input gaps.
    fcnt      = 0;
    read_pct  = 50;
    flag_mode = 1;
    for (int i = 0; i < 300; i++) begin
      send(W'($urandom_range(255)));
      if ($urandom_range(2) == 0) idle($urandom_range(2));
    end
    idle(0);
    read_pct = 100;
    drain(2000);
    flag_mode = 0;

`ifdef CHAN2PUSH_STATS_EN
    do_reset();
    bif.ofull = 1'b1;
    a0 = n_acc;
    fork
      begin
        for (int i = 0; i < 10; i++) send(W'(8'h40 + i));
        idle(0);
      end
      begin
        wait (n_acc > a0);
        repeat (3) @(posedge clock);
        #1;
        bif.ofull = 1'b0;
      end
    join
    idle(10);
    check("stats_wcount", wcount, 10);
    check("stats_stalls", stalls, 3);
`else
    a0 = n_acc;
    check("accepted_words", a0, 8 + 6 + 2 + 4 + 1000 + 300);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
